// File: rtl/switch_arbiter.sv
// switch_arbiter: input-side controller for the lab-3 switch-driven FSM.
// Synchronizes and debounces four raw switches, latches each debounced press
// as a pending request and hands out single-cycle one-hot grants in
// round-robin order, so the downstream FSM sees one switch per transition.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   sw_raw   raw asynchronous switch levels (bit 0 = SW1 .. bit 3 = SW4)
//   grant    registered one-hot single-cycle grant, 0 otherwise
//   pending  latched requests not yet granted
//   busy     high while the arbiter FSM is outside IDLE

// Per-switch 2-flop synchronizer plus counting debouncer.
module switch_arbiter_db #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        // this edge would bring the count to DEBOUNCE_CYCLES: accept new level
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

module switch_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_raw,
  output logic [3:0] grant,
  output logic [3:0] pending,
  output logic       busy
);
  localparam int unsigned NUM_SW = 4;
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t            state;
  logic [NUM_SW-1:0] stable, stable_q, rise, clr;
  logic [1:0]        ptr, winner, win_c;
  logic [7:0]        gap_cnt;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_db
    switch_arbiter_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (sw_raw[i]),
      .stable (stable[i])
    );
  end

  // Only rising edges of the debounced level count as presses.
  assign rise = stable & ~stable_q;
  assign clr  = (state == GRANT) ? (4'b0001 << winner) : 4'b0000;
  assign busy = (state != IDLE);

  // Round-robin search: scan offsets high to low so the lowest offset from
  // ptr is the last (and therefore winning) assignment.
  always_comb begin
    win_c = ptr;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (pending[ptr + 2'(i)]) win_c = ptr + 2'(i);
    end
  end

  // A new press landing on the clear cycle of the same bit keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q <= '0;
      pending  <= '0;
    end else begin
      stable_q <= stable;
      pending  <= (pending & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      winner  <= '0;
      grant   <= '0;
      ptr     <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending != '0) begin
            winner <= win_c;
            grant  <= 4'b0001 << win_c;
            state  <= GRANT;
          end
        end
        GRANT: begin
          grant   <= '0;
          ptr     <= winner + 2'd1;
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_switch_arbiter.sv
// Directed testbench for switch_arbiter with default parameters.
// Edge k of a scenario is the k-th rising edge after sw_raw is changed;
// outputs are sampled 1 time unit after each edge.
module tb_switch_arbiter;
  logic       clk;
  logic       reset;
  logic [3:0] sw_raw;
  logic [3:0] grant;
  logic [3:0] pending;
  logic       busy;

  int pass_cnt;
  int total_cnt;

  switch_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .sw_raw  (sw_raw),
    .grant   (grant),
    .pending (pending),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sw_raw = 4'b0000;
    repeat (n) step();
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if (grant !== 4'b0000) $display("FAIL reset_grant got %b want 0000", grant);
    else pass_cnt++;
    total_cnt++;
    if (pending !== 4'b0000) $display("FAIL reset_pending got %b want 0000", pending);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] eg, ep;
    logic       eb;
    sw_raw = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      step();
      eg = (k == 7) ? 4'b0001 : 4'b0000;
      ep = (k == 6 || k == 7) ? 4'b0001 : 4'b0000;
      eb = (k >= 7 && k <= 9);
      total_cnt++;
      if (grant !== eg) $display("FAIL single_grant edge %0d got %b want %b", k, grant, eg);
      else pass_cnt++;
      total_cnt++;
      if (pending !== ep) $display("FAIL single_pending edge %0d got %b want %b", k, pending, ep);
      else pass_cnt++;
      total_cnt++;
      if (busy !== eb) $display("FAIL single_busy edge %0d got %b want %b", k, busy, eb);
      else pass_cnt++;
    end
    idle(20);
  endtask

  task automatic test_glitch();
    sw_raw = 4'b0100;
    for (int k = 0; k < 15; k++) begin
      step();
      if (k == 2) sw_raw = 4'b0000;
      total_cnt++;
      if (pending !== 4'b0000) $display("FAIL glitch_pending edge %0d got %b want 0000", k, pending);
      else pass_cnt++;
      total_cnt++;
      if (grant !== 4'b0000) $display("FAIL glitch_grant edge %0d got %b want 0000", k, grant);
      else pass_cnt++;
    end
    idle(10);
  endtask

  // ptr is 1 here (last grant was bit 0), so the first grant is bit 1.
  task automatic test_reset_mid();
    sw_raw = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 6) begin
        total_cnt++;
        if (pending !== 4'b1111) $display("FAIL midrst_pre_pending got %b want 1111", pending);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (grant !== 4'b0010) $display("FAIL midrst_pre_grant got %b want 0010", grant);
    else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (grant !== 4'b0000) $display("FAIL midrst_grant got %b want 0000", grant);
    else pass_cnt++;
    total_cnt++;
    if (pending !== 4'b0000) $display("FAIL midrst_pending got %b want 0000", pending);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy);
    else pass_cnt++;
    repeat (2) step();
    total_cnt++;
    if ({grant, pending, busy} !== 9'd0) $display("FAIL midrst_hold got %b want 0", {grant, pending, busy});
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Continues straight from reset release with all four switches held.
  task automatic test_simultaneous();
    logic [3:0] eg, ep;
    logic       eb;
    for (int k = 0; k < 23; k++) begin
      step();
      case (k)
        7:       eg = 4'b0001;
        11:      eg = 4'b0010;
        15:      eg = 4'b0100;
        19:      eg = 4'b1000;
        default: eg = 4'b0000;
      endcase
      if (k < 6)       ep = 4'b0000;
      else if (k < 8)  ep = 4'b1111;
      else if (k < 12) ep = 4'b1110;
      else if (k < 16) ep = 4'b1100;
      else if (k < 20) ep = 4'b1000;
      else             ep = 4'b0000;
      eb = (k >= 7 && k <= 21) && (((k - 7) % 4) != 3);
      total_cnt++;
      if (grant !== eg) $display("FAIL simul_grant edge %0d got %b want %b", k, grant, eg);
      else pass_cnt++;
      total_cnt++;
      if (pending !== ep) $display("FAIL simul_pending edge %0d got %b want %b", k, pending, ep);
      else pass_cnt++;
      total_cnt++;
      if (busy !== eb) $display("FAIL simul_busy edge %0d got %b want %b", k, busy, eb);
      else pass_cnt++;
    end
    idle(20);
  endtask

  task automatic test_round_robin();
    logic [3:0] eg, ep;
    // grant bit 2 alone so ptr moves to 3
    sw_raw = 4'b0100;
    for (int k = 0; k < 11; k++) begin
      step();
      if (k == 7) begin
        total_cnt++;
        if (grant !== 4'b0100) $display("FAIL rr_first_grant got %b want 0100", grant);
        else pass_cnt++;
      end
    end
    idle(20);
    sw_raw = 4'b0101;
    for (int k = 0; k < 15; k++) begin
      step();
      case (k)
        7:       eg = 4'b0001;
        11:      eg = 4'b0100;
        default: eg = 4'b0000;
      endcase
      if (k < 6)       ep = 4'b0000;
      else if (k < 8)  ep = 4'b0101;
      else if (k < 12) ep = 4'b0100;
      else             ep = 4'b0000;
      total_cnt++;
      if (grant !== eg) $display("FAIL rr_grant edge %0d got %b want %b", k, grant, eg);
      else pass_cnt++;
      total_cnt++;
      if (pending !== ep) $display("FAIL rr_pending edge %0d got %b want %b", k, pending, ep);
      else pass_cnt++;
    end
    idle(20);
  endtask

  // ptr is 3: bits 3 and 0 are served first, delaying bit 1's GRANT to
  // edge 15. Bit 1 is released (samples 5..9) and re-pressed from edge 10,
  // so its second debounced rise sets pending on edge 16, the clear edge.
  task automatic test_collision();
    logic [3:0] eg, ep;
    sw_raw = 4'b1011;
    for (int k = 0; k < 23; k++) begin
      step();
      if (k == 4) sw_raw[1] = 1'b0;
      if (k == 9) sw_raw[1] = 1'b1;
      case (k)
        7:       eg = 4'b1000;
        11:      eg = 4'b0001;
        15:      eg = 4'b0010;
        19:      eg = 4'b0010;
        default: eg = 4'b0000;
      endcase
      if (k < 6)       ep = 4'b0000;
      else if (k < 8)  ep = 4'b1011;
      else if (k < 12) ep = 4'b0011;
      else if (k < 20) ep = 4'b0010;
      else             ep = 4'b0000;
      total_cnt++;
      if (grant !== eg) $display("FAIL coll_grant edge %0d got %b want %b", k, grant, eg);
      else pass_cnt++;
      total_cnt++;
      if (pending !== ep) $display("FAIL coll_pending edge %0d got %b want %b", k, pending, ep);
      else pass_cnt++;
    end
    idle(10);
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b0;
    sw_raw    = 4'b0000;
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_glitch();
    test_reset_mid();
    test_simultaneous();
    test_round_robin();
    test_collision();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

Input-side controller for the lab-3 switch-driven state machine. Synchronizes and debounces four raw board switches, latches each debounced press as a pending request, and issues at most one single-cycle one-hot grant at a time, in round-robin order. The state machine therefore only ever sees exactly one switch active per transition. Sits between the board switch pins and the state machine's SW1..SW4 inputs.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized level must differ from the debounced level before the debounced level flips; legal range 1..255.
- GAP_CYCLES, 2: idle cycles forced after every grant; legal range 1..255.
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately on assertion; deassertion is synchronous to clk.
- sw_raw  in  4  raw, asynchronous switch levels; bit 0 = SW1 … bit 3 = SW4.
- grant  out  4  one-hot, registered, single-cycle pulse selecting the switch forwarded to the state machine; 0 otherwise.
- pending  out  4  registered latched requests not yet granted.
- busy  out  1  high whenever the arbiter FSM is not in IDLE.

## Operation
- Synchronizer: two flops per bit; reset value 0.
- Debouncer, per bit:
  - Holds a stable level (reset 0) and an 8-bit counter (reset 0).
  - When the synchronized bit equals stable, the counter clears.
  - Otherwise the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, stable toggles and the counter clears.
- Request latch:
  - A 0->1 transition of stable[i] sets pending[i] on the next edge.
  - 1->0 transitions are ignored.
  - A press while pending[i]=1 is absorbed; presses are not counted.
- Round-robin pointer ptr (2 bits, reset 0):
  - Winner = first set pending bit searching ptr, ptr+1, … mod 4.
  - After a grant, ptr = winner+1 mod 4.
- Arbiter FSM, states IDLE / GRANT / GAP, reset to IDLE:
  - IDLE: if pending≠0, register winner, go to GRANT; else stay.
  - GRANT (exactly 1 cycle): grant = onehot(winner). Clear pending[winner] at the end of the cycle. Update ptr. Go to GAP.
  - GAP: grant = 0; count GAP_CYCLES cycles, then go to IDLE.
- Simultaneous set and clear of the same pending bit (new debounced press arriving on the GRANT cycle for that bit): set wins, pending stays 1.
- Simultaneous presses on several bits: all latch; they are granted one per GRANT in round-robin order.
- Reset mid-operation (any state, including GRANT): all outputs go to 0 asynchronously, FSM to IDLE, ptr to 0, counters and stable levels to 0. The partially issued grant is dropped.

## Timing
- Reset values: grant=4'b0000, pending=4'b0000, busy=0.
- Latency: count the first edge sampling sw_raw[i]=1 as edge 0. With the FSM idle and no other pending bits:
  - stable[i] flips at edge DEBOUNCE_CYCLES+1.
  - pending[i] rises at edge DEBOUNCE_CYCLES+2.
  - grant[i] is high for the one cycle following edge DEBOUNCE_CYCLES+3 (edge 7 for the defaults).
- Grant spacing: consecutive grants are at least GAP_CYCLES+2 cycles apart (GRANT, GAP_CYCLES×GAP, IDLE).
- busy is high from the edge entering GRANT until the edge returning to IDLE.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles never reach stable.
- grant is never multi-hot and never held more than 1 cycle.

## Test plan
- Reset: drive reset=0 mid-sim with sw_raw=4'b1111 → grant, pending and busy read 0 immediately (asynchronously); after release, no grant until the full debounce latency elapses.
- Single press, defaults: sw_raw=4'b0001 from edge 0 → pending=0001 after edge 6, grant=0001 for exactly the cycle after edge 7, pending=0000 after edge 8, busy high for 3 cycles.
- Glitch rejection: sw_raw[2] high for 3 cycles, then low → stable, pending and grant stay 0.
- Simultaneous press: sw_raw=4'b1111 at once, ptr=0 → grants 0001, 0010, 0100, 1000 in order, each separated by 4 cycles; pending ends at 0.
- Round-robin fairness: after granting bit 2, with pending=4'b0101 → next grant 0001 (searching from bit 3, which is not set, then wrapping to bit 0), then 0100.
- Set-vs-clear collision: debounced re-press of bit 1 lands on its GRANT cycle → pending[1] remains 1 and a second grant 0010 follows after the gap.
